// File: rtl/aoc_result_reporter_pkg.sv
// Shared definitions for the AoC board-level reporter: FSM state encoding,
// ASCII constants, the default baud divisor and the double-dabble nibble step.
package aoc_result_reporter_pkg;

    // Reporter sequence: IDLE -> KICK -> WAIT -> CONV -> SEND -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_WAIT,
        ST_CONV,
        ST_SEND
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 12 MHz board clock at 115200 baud
    localparam int CLK_HZ               = 12_000_000;
    localparam int BAUD                 = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the
    // shift so that it carries correctly into the next decade. The add is
    // 4 bits wide; the largest input (9) gives 12, so nothing is lost.
    function automatic logic [3:0] dabble_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, idle high.
// Accepts a byte on tx_start while tx_busy is low; tx_busy drops on the edge
// that ends the stop bit, so a following byte can be queued right away.
module uart_tx
    import aoc_result_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] clk_cnt;   // cycles spent in the current bit
    logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]       frame;     // remaining data bits followed by the stop bit

    // Frame shifter: load on tx_start, advance one bit every CLKS_PER_BIT cycles
    // NOTE: clocked state is written only with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx      <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            frame   <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                tx      <= 1'b0;
                frame   <= {1'b1, tx_data};
                clk_cnt <= '0;
                bit_idx <= '0;
            end
        end else if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
                // Stop bit complete; line is already high and stays idle
                tx_busy <= 1'b0;
            end else begin
                tx      <= frame[0];
                frame   <= {1'b1, frame[8:1]};
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aoc_result_reporter.sv
// Board-level driver for an AoC puzzle core: kicks the core, waits for its
// answer, converts it to decimal with double-dabble and prints it on a UART
// as ASCII digits (no leading zeros) followed by CR LF.
module aoc_result_reporter
    import aoc_result_reporter_pkg::*;
#(
    parameter int RESULT_W     = 11,
    parameter int DIGITS       = 4,
    parameter int CLKS_PER_BIT = 104,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                core_done,
    input  logic [RESULT_W-1:0] core_result,
    output logic                core_start,
    output logic                uart_tx,
    output logic                busy
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int DD_W   = BCD_W + RESULT_W;
    localparam int BYTES  = DIGITS + 2;            // digits plus CR LF
    localparam int IDX_W  = $clog2(BYTES + 1);
    localparam int CONV_W = $clog2(RESULT_W + 1);

    state_t            state;
    logic              auto_pend;    // one automatic run still owed after reset
    logic              wait_first;   // first WAIT cycle: core_done may be stale
    logic [DD_W-1:0]   dd;           // {BCD digits, binary being shifted out}
    logic [CONV_W-1:0] conv_cnt;
    logic [IDX_W-1:0]  byte_idx;     // next byte position: 0..DIGITS-1 digits, then CR, LF
    logic              started;      // first (most significant printed) byte issued
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;

    logic [DD_W-1:0]   dd_adj;
    logic [DD_W-1:0]   dd_next;
    logic [BCD_W-1:0]  bcd;
    logic [IDX_W-1:0]  first_pos;
    logic [IDX_W-1:0]  send_pos;
    logic [3:0]        digit;
    logic [7:0]        next_byte;
    logic              all_issued;
    logic              report_done;

    // One double-dabble step: correct every BCD nibble, then shift left by one
    // NOTE: combinational blocks assign every output a default first, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        dd_adj = dd;
        for (int d = 0; d < DIGITS; d++) begin
            dd_adj[RESULT_W + 4*d +: 4] = dabble_nibble(dd[RESULT_W + 4*d +: 4]);
        end
        dd_next = {dd_adj[DD_W-2:0], 1'b0};
    end

    assign bcd = dd[DD_W-1 -: BCD_W];

    // Leading-zero suppression: position of the first non-zero digit, with the
    // least-significant digit always printed even when the value is zero
    always_comb begin
        first_pos = IDX_W'(DIGITS - 1);
        for (int p = DIGITS - 1; p >= 0; p--) begin
            if (bcd[4*(DIGITS-1-p) +: 4] != 4'd0) begin
                first_pos = IDX_W'(p);
            end
        end
    end

    assign send_pos = started ? byte_idx : first_pos;

    // Byte mux: ASCII digit for digit positions, then CR and LF
    always_comb begin
        digit = 4'd0;
        for (int p = 0; p < DIGITS; p++) begin
            if (send_pos == IDX_W'(p)) begin
                digit = bcd[4*(DIGITS-1-p) +: 4];
            end
        end
        if (send_pos == IDX_W'(DIGITS)) begin
            next_byte = ASCII_CR;
        end else if (send_pos == IDX_W'(DIGITS + 1)) begin
            next_byte = ASCII_LF;
        end else begin
            next_byte = ASCII_0 + {4'd0, digit};
        end
    end

    assign all_issued  = started && (byte_idx == IDX_W'(BYTES));
    // tx_start still high means the UART has not yet taken the byte
    assign report_done = all_issued && !tx_busy && !tx_start;

    // Reporter FSM with registered core_start, busy and UART handshake
    // NOTE: the conversion register is a plain register, not a memory, so it is
    // cleared on reset like every other piece of state here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            core_start <= 1'b0;
            busy       <= 1'b0;
            auto_pend  <= AUTO_START;
            wait_first <= 1'b0;
            dd         <= '0;
            conv_cnt   <= '0;
            byte_idx   <= '0;
            started    <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (go || auto_pend) begin
                        auto_pend  <= 1'b0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_KICK;
                    end
                end
                ST_KICK: begin
                    wait_first <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (core_done) begin
                        dd       <= {{BCD_W{1'b0}}, core_result};
                        conv_cnt <= '0;
                        state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    dd <= dd_next;
                    if (conv_cnt == CONV_W'(RESULT_W - 1)) begin
                        byte_idx <= '0;
                        started  <= 1'b0;
                        state    <= ST_SEND;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (report_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!all_issued && !tx_busy && !tx_start) begin
                        tx_start <= 1'b1;
                        tx_data  <= next_byte;
                        byte_idx <= send_pos + 1'b1;
                        started  <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx       (uart_tx)
    );

endmodule

// File: tb/tb_aoc_result_reporter.sv
// Directed bench for aoc_result_reporter: a behavioural core answers each
// start, a UART line monitor decodes frames and pops the expected text from a
// scoreboard filled when each run is requested.
module tb_aoc_result_reporter;

    localparam int RESULT_W = 11;
    localparam int DIGITS   = 4;
    localparam int CPB      = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                go = 1'b0;
    logic                core_done;
    logic [RESULT_W-1:0] core_result;
    logic                core_start;
    logic                uart_tx;
    logic                busy;

    int                  errors = 0;
    int                  checks = 0;
    logic [7:0]          exp_q[$];
    int                  start_cnt = 0;
    int                  core_value = 0;
    logic                lf_seen = 1'b0;

    // monitor state
    logic                in_frame = 1'b0;
    logic                gap_track = 1'b0;
    int                  idle_cnt = 0;
    int                  mon_bit = 0;
    int                  mon_cnt = 0;
    logic                bit_val = 1'b1;
    logic                bad = 1'b0;
    logic [7:0]          rx_byte = '0;
    logic [7:0]          exp_byte;

    always #5 clk = ~clk;

    aoc_result_reporter #(
        .RESULT_W     (RESULT_W),
        .DIGITS       (DIGITS),
        .CLKS_PER_BIT (CPB),
        .AUTO_START   (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .core_done   (core_done),
        .core_result (core_result),
        .core_start  (core_start),
        .uart_tx     (uart_tx),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural core: registers start, clears its stale done one edge later,
    // then raises done with the answer about 20 cycles after the start pulse.
    logic core_pend;
    int   core_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done   <= 1'b0;
            core_result <= '0;
            core_pend   <= 1'b0;
            core_cnt    <= 0;
        end else begin
            core_pend <= core_start;
            if (core_pend) begin
                core_done <= 1'b0;
                core_cnt  <= 19;
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    core_done   <= 1'b1;
                    core_result <= RESULT_W'(core_value);
                end
            end
        end
    end

    // Line monitor: start-pulse counter, 8N1 decoder, bit-width and gap checks
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && core_start === 1'b1) start_cnt++;
            if (!rst_n) begin
                in_frame  = 1'b0;
                gap_track = 1'b0;
                idle_cnt  = 0;
            end else begin
                if (!in_frame) begin
                    if (uart_tx === 1'b0) begin
                        if (gap_track) check("frame_gap_le2", (idle_cnt <= 2), 1);
                        in_frame = 1'b1;
                        mon_bit  = 0;
                        mon_cnt  = 0;
                        bad      = 1'b0;
                    end else begin
                        idle_cnt++;
                    end
                end
                if (in_frame) begin
                    if (mon_cnt == 0) bit_val = uart_tx;
                    else if (uart_tx !== bit_val) bad = 1'b1;
                    mon_cnt++;
                    if (mon_cnt == CPB) begin
                        mon_cnt = 0;
                        if (mon_bit == 0 && bit_val !== 1'b0) bad = 1'b1;
                        if (mon_bit >= 1 && mon_bit <= 8) rx_byte[mon_bit-1] = bit_val;
                        if (mon_bit == 9) begin
                            check("stop_bit", bit_val, 1);
                            check("bit_width", bad, 0);
                            check("sb_nonempty", (exp_q.size() > 0), 1);
                            if (exp_q.size() > 0) begin
                                exp_byte = exp_q.pop_front();
                                check("rx_byte", rx_byte, exp_byte);
                            end
                            if (rx_byte == 8'h0A) lf_seen = 1'b1;
                            in_frame  = 1'b0;
                            idle_cnt  = 0;
                            gap_track = (rx_byte != 8'h0A);
                        end else begin
                            mon_bit++;
                        end
                    end
                end
            end
        end
    end

    // Expected text for a value: decimal without leading zeros, then CR LF
    task automatic push_report(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_report(input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, (n < 3000), 1);
    endtask

    task automatic wait_queue_le(input int lim, input string tag);
        int n = 0;
        while (exp_q.size() > lim && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_time"}, (n < 3000), 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int starts;

        // Reset state
        core_value = 1507;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_core_start", core_start, 0);
        check("rst_busy", busy, 0);

        // Automatic run after reset release
        push_report(1507);
        rst_n = 1'b1;
        wait_report("auto_1507");
        check("auto_start_count", start_cnt, 1);
        check("auto_busy_low", busy, 0);
        repeat (60) @(negedge clk);
        check("no_second_auto_run", start_cnt, 1);

        // Zero, two digits, full scale; core still holds stale done each time
        core_value = 0;
        push_report(0);
        pulse_go();
        wait_report("val_0");
        check("start_count_0", start_cnt, 2);

        core_value = 40;
        push_report(40);
        pulse_go();
        wait_report("val_40");

        core_value = 2047;
        push_report(2047);
        pulse_go();
        wait_report("val_2047");
        check("start_count_2047", start_cnt, 4);

        // go during WAIT, CONV, SEND and on the return to IDLE is ignored
        core_value = 1234;
        push_report(1234);
        pulse_go();
        repeat (5) @(negedge clk);
        pulse_go();                       // WAIT
        repeat (20) @(negedge clk);
        pulse_go();                       // CONV
        wait_queue_le(4, "reach_send");
        pulse_go();                       // SEND
        lf_seen = 1'b0;
        n = 0;
        while (!lf_seen && n < 50000) begin
            #1;
            n++;
        end
        check("lf_seen_in_time", (n < 50000), 1);
        @(posedge clk);                   // stop bit of LF ends here
        @(negedge clk);
        go = 1'b1;                        // sampled on the edge that returns to IDLE
        @(negedge clk);
        go = 1'b0;
        repeat (60) @(negedge clk);
        check("ignored_go_starts", start_cnt, 5);
        check("ignored_go_busy", busy, 0);
        check("ignored_go_no_extra_bytes", exp_q.size(), 0);

        // A go in IDLE afterwards produces a full report
        core_value = 305;
        push_report(305);
        pulse_go();
        wait_report("val_305");
        check("start_count_305", start_cnt, 6);

        // Reset in the middle of the second byte
        core_value = 1507;
        push_report(1507);
        pulse_go();
        wait_queue_le(5, "first_byte");
        repeat (20) @(negedge clk);
        check("mid_frame_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_uart_tx", uart_tx, 1);
        check("rst_async_core_start", core_start, 0);
        check("rst_async_busy", busy, 0);
        exp_q.delete();
        starts = start_cnt;
        core_value = 88;
        push_report(88);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_report("after_reset_88");
        check("after_reset_one_start", start_cnt, starts + 1);
        check("final_uart_idle", uart_tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
